// File: rtl/video_pkg.sv
// video_pkg
//   Definitions shared by the video input and output paths.
//   - Default raster geometry (active area plus blanking).
//   - Pixel and packed-word types. A 32-bit FIFO word carries four pixels,
//     with the leftmost pixel in the most significant byte.
//   - The output-side FSM state type.
package video_pkg;

  localparam int p_WIDTH  = 640;  // active pixels per line
  localparam int p_HEIGHT = 480;  // active lines per frame
  localparam int p_LSYNC  = 160;  // horizontal blanking cycles per line
  localparam int p_FSYNC  = 40;   // vertical blanking lines per frame

  localparam int H_TOTAL = p_WIDTH + p_LSYNC;
  localparam int V_TOTAL = p_HEIGHT + p_FSYNC;

  // Width of the raster counters (h and v)
  localparam int CNT_W = 10;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    pixel_t pixel_0;  // leftmost pixel, bits [31:24]
    pixel_t pixel_1;
    pixel_t pixel_2;
    pixel_t pixel_3;  // rightmost pixel, bits [7:0]
  } pixel_pack_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } out_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster counters for the output path.
//   - h_cnt runs 0..p_WIDTH+p_LSYNC-1.
//   - v_cnt advances each time h_cnt wraps, and runs 0..p_HEIGHT+p_FSYNC-1.
//   - Both counters hold while run is low.
// Ports:
//   clk, nRST    clock and asynchronous active-low reset
//   run          counter enable
//   active       current (h,v) is inside the active picture
//   fv           current line is one of the active lines
//   group_start  first pixel of a 4-pixel group inside the active picture
//   pix_phase    h_cnt[1:0], the pixel position within its group
module video_timing_gen #(
  parameter int p_WIDTH  = video_pkg::p_WIDTH,
  parameter int p_HEIGHT = video_pkg::p_HEIGHT,
  parameter int p_LSYNC  = video_pkg::p_LSYNC,
  parameter int p_FSYNC  = video_pkg::p_FSYNC
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       run,
  output logic       active,
  output logic       fv,
  output logic       group_start,
  output logic [1:0] pix_phase
);
  import video_pkg::*;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(p_WIDTH);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(p_HEIGHT);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(p_WIDTH + p_LSYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(p_HEIGHT + p_FSYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign fv          = (v_cnt < V_ACT);
  assign pix_phase   = h_cnt[1:0];
  assign group_start = active && (h_cnt[1:0] == 2'b00);

endmodule

// File: rtl/video_out_gen.sv
// video_out_gen
//   Pops 32-bit words (4 packed pixels) from a show-ahead FIFO and streams
//   them one pixel per clock with line_valid/frame_valid framing.
//   - After reset the block waits in IDLE until the FIFO holds a word.
//   - It then runs frames back-to-back and never stalls. A group whose
//     word is missing is sent as four zero pixels and flagged on underrun.
// Ports:
//   clk, nRST    clock and asynchronous active-low reset
//   fifo_data    FIFO head word; pixel_0 is in [31:24]
//   fifo_empty   FIFO has no valid head word
//   r_e          pop strobe (combinational), one cycle per consumed word
//   pixel_out    current pixel, 0 outside the active area
//   line_valid   active pixel of an active line
//   frame_valid  active lines, including their horizontal blanking
//   underrun     one-cycle pulse after a group start that found the FIFO empty
//   fsm_state    current FSM state, for observation
module video_out_gen #(
  parameter int p_WIDTH  = video_pkg::p_WIDTH,
  parameter int p_HEIGHT = video_pkg::p_HEIGHT,
  parameter int p_LSYNC  = video_pkg::p_LSYNC,
  parameter int p_FSYNC  = video_pkg::p_FSYNC
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic [31:0]            fifo_data,
  input  logic                   fifo_empty,
  output logic                   r_e,
  output logic [7:0]             pixel_out,
  output logic                   line_valid,
  output logic                   frame_valid,
  output logic                   underrun,
  output video_pkg::out_state_t  fsm_state
);
  import video_pkg::*;

  if (p_WIDTH % 4 != 0) begin : g_width_check
    $error("video_out_gen: p_WIDTH (%0d) must be a multiple of 4", p_WIDTH);
  end

  // FIFO handshake: a word is consumed on any cycle where r_e is high.
  // r_e can only rise when fifo_empty is low, so the FIFO never sees a
  // pop while it is empty.

  out_state_t  state;
  pixel_pack_t word_hold;
  pixel_pack_t fifo_word;
  logic        run;
  logic        active;
  logic        fv;
  logic        group_start;
  logic [1:0]  pix_phase;

  assign fifo_word = fifo_data;
  assign run       = (state == ST_RUN);
  assign fsm_state = state;

  video_timing_gen #(
    .p_WIDTH  (p_WIDTH),
    .p_HEIGHT (p_HEIGHT),
    .p_LSYNC  (p_LSYNC),
    .p_FSYNC  (p_FSYNC)
  ) u_timing (
    .clk         (clk),
    .nRST        (nRST),
    .run         (run),
    .active      (active),
    .fv          (fv),
    .group_start (group_start),
    .pix_phase   (pix_phase)
  );

  assign r_e = run && group_start && !fifo_empty;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      word_hold   <= '0;
      pixel_out   <= '0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pixel_out   <= '0;
          line_valid  <= 1'b0;
          frame_valid <= 1'b0;
          underrun    <= 1'b0;
          if (!fifo_empty) state <= ST_RUN;
        end
        ST_RUN: begin
          line_valid  <= active;
          frame_valid <= fv;
          underrun    <= group_start && fifo_empty;
          // A missing word is replaced by zeros so the whole group blanks
          if (group_start) word_hold <= fifo_empty ? '0 : fifo_word;
          if (!active) begin
            pixel_out <= '0;
          end else begin
            // Phase 0 reads the FIFO head directly; word_hold only lands
            // at the end of this cycle
            case (pix_phase)
              2'd0:    pixel_out <= fifo_empty ? '0 : fifo_word.pixel_0;
              2'd1:    pixel_out <= word_hold.pixel_1;
              2'd2:    pixel_out <= word_hold.pixel_2;
              default: pixel_out <= word_hold.pixel_3;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
